regfile_scoreboard: RTL

// - Architectural GPR file at the receiving end of the WB->RF write bus, plus a per-register pending-write scoreboard.
// - Accepts {rf_we, rf_waddr, rf_wdata} from the writeback stage.
// - Serves two combinational read ports to the decode stage, with same-cycle write-through.
// - Tracks writes issued from decode and not yet retired, and flags each read operand as busy so decode can stall.

---
 rtl/regfile_scoreboard_if.sv | 38 +++
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bundle between decode/writeback and the GPR file with its pending-write scoreboard.
//   master : pipeline side (drives write bus, issue info, read addresses)
//   slave  : register file side (returns read data, busy flags, sticky error)
// Signals:
//   ws_to_rf_bus  write bus: [AW+DW]=we, [AW+DW-1:DW]=waddr, [DW-1:0]=wdata
//   id_issue      decode hands an instruction to EX this cycle
//   id_gr_we      issued instruction writes a GPR
//   id_dest       destination register of the issued instruction
//   raddr1/2      read port addresses
//   rdata1/2      read port data (combinational)
//   rbusy1/2      operand still has an unretired pending write
//   sb_err        sticky scoreboard overflow/underflow flag
interface regfile_scoreboard_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic [AW+DW:0] ws_to_rf_bus;
  logic           id_issue;
  logic           id_gr_we;
  logic [AW-1:0]  id_dest;
  logic [AW-1:0]  raddr1;
  logic [AW-1:0]  raddr2;
  logic [DW-1:0]  rdata1;
  logic [DW-1:0]  rdata2;
  logic           rbusy1;
  logic           rbusy2;
  logic           sb_err;

  modport master (
    output ws_to_rf_bus, id_issue, id_gr_we, id_dest, raddr1, raddr2,
    input  rdata1, rdata2, rbusy1, rbusy2, sb_err
  );

  modport slave (
    input  ws_to_rf_bus, id_issue, id_gr_we, id_dest, raddr1, raddr2,
    output rdata1, rdata2, rbusy1, rbusy2, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural GPR file with two combinational read ports (write-through from the
// writeback bus) and a per-register pending-write counter scoreboard.
// Ports:
//   clk    clock
//   reset  synchronous, active-high; clears GPRs, counters and sb_err
//   rf     regfile_scoreboard_if.slave bundle (write bus, issue info, read ports, flags)
// r0 reads as zero, ignores writes and never accumulates pending counts.
module regfile_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 3
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave rf
);

  localparam logic [CNTW-1:0] CntMax = '1;

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  assign we    = rf.ws_to_rf_bus[AW+DW];
  assign waddr = rf.ws_to_rf_bus[AW+DW-1:DW];
  assign wdata = rf.ws_to_rf_bus[DW-1:0];

  logic [DW-1:0]   gpr_q [NREG];
  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic            err_q, err_d;
  logic [NREG-1:0] inc_vec, dec_vec;

  // Per-register issue (increment) and retire (decrement) strobes; r0 never set.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      inc_vec[r] = rf.id_issue && rf.id_gr_we && (rf.id_dest == AW'(r));
      dec_vec[r] = we && (waddr == AW'(r));
    end
  end

  // Counter next state; saturate at both ends and latch the error instead of wrapping.
  always_comb begin
    err_d    = err_q;
    cnt_d[0] = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] == CntMax) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + 1'b1;
        end
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (we && (waddr != '0)) begin
        gpr_q[waddr] <= wdata;
      end
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Read ports: r0 is zero, a same-cycle write to the address is forwarded.
  always_comb begin
    rf.rdata1 = '0;
    if (rf.raddr1 != '0) begin
      rf.rdata1 = (we && (waddr == rf.raddr1)) ? wdata : gpr_q[rf.raddr1];
    end
  end

  always_comb begin
    rf.rdata2 = '0;
    if (rf.raddr2 != '0) begin
      rf.rdata2 = (we && (waddr == rf.raddr2)) ? wdata : gpr_q[rf.raddr2];
    end
  end

  // Busy unless the only outstanding write retires this cycle (its data is forwarded).
  // Issues this cycle are not seen until the counter updates.
  logic ret1, ret2;
  assign ret1 = we && (waddr == rf.raddr1);
  assign ret2 = we && (waddr == rf.raddr2);

  assign rf.rbusy1 = (rf.raddr1 != '0) && (cnt_q[rf.raddr1] != CNTW'(ret1));
  assign rf.rbusy2 = (rf.raddr2 != '0) && (cnt_q[rf.raddr2] != CNTW'(ret2));

  assign rf.sb_err = err_q;

endmodule
